// File: rtl/vga_fb_pkg.sv
// Shared constants and types for the VGA frame-buffer arbiter.
package vga_fb_pkg;

  localparam int FB_ADDR_W      = 15;     // frame-buffer word address width
  localparam int FB_DATA_W      = 16;     // pixels per word, RAM data width
  localparam int FB_FRAME_WORDS = 19200;  // 640*480/16 words per frame
  localparam int LINE_WORDS     = 40;     // words per 640-pixel scan line

  // Names the RAM operation that goes out on the memory port next cycle
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2
  } grant_t;

endpackage

// File: rtl/vga_fb_fifo.sv
// Show-ahead prefetch FIFO: the head word is visible without a pop, and
// reads as zero while empty. A flush empties it in one cycle and wins
// over a simultaneous push.
module vga_fb_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              do_pop;

  // A pop against an empty FIFO is ignored here; the caller flags it
  assign do_pop = pop & (count_reg != '0);

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Word storage; contents need no reset because empty masks the head
  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr_reg] <= push_data;
  end

  assign empty     = (count_reg == '0);
  assign count     = count_reg;
  assign head_data = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer port arbiter: shares one single-port RAM between VGA
// scan-out prefetch and a host writer. Grant in cycle N, RAM op on MEM_*
// in N+1, read data pushed into the prefetch FIFO in N+2.
// Optional feature: define FB_ARB_STARVE_EN to bound host write latency
// once the FIFO holds at least one word.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int ADDR_W      = FB_ADDR_W,
  parameter int DATA_W      = FB_DATA_W,
  parameter int FRAME_WORDS = FB_FRAME_WORDS,
  parameter int FIFO_DEPTH  = 4,
  parameter int LOW_WATER   = 2,
  parameter int STARVE_MAX  = 8
) (
  input  logic              OSC_50,
  input  logic              RST_N,
  input  logic              FRAME_START,
  input  logic              POP,
  output logic [DATA_W-1:0] POP_DATA,
  output logic              FIFO_EMPTY,
  output logic              UNDERRUN,
  input  logic              WR_VALID,
  output logic              WR_READY,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [DATA_W-1:0] WR_DATA,
  output logic              MEM_EN,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int FILL_W = $clog2(FIFO_DEPTH + 3);

  grant_t            state_reg;
  grant_t            grant_next;
  logic              mem_en_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic [ADDR_W-1:0] fetch_addr_reg;
  logic              rd_data_reg;        // read data is on MEM_RDATA this cycle
  logic              rd_data_stale_reg;  // that data belongs to an abandoned frame
  logic              underrun_reg;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_push;
  logic              rd_bus;
  logic [1:0]        inflight;
  logic [FILL_W-1:0] fill;
  logic              fetch_ok;
  logic              starve;

  // A read on the bus and a read returning data both hold a FIFO slot
  assign rd_bus   = (state_reg == FETCH);
  assign inflight = {1'b0, rd_bus} + {1'b0, rd_data_reg};
  assign fill     = FILL_W'(fifo_count) + FILL_W'(inflight);
  assign fetch_ok = (fill < FILL_W'(FIFO_DEPTH)) &&
                    (fetch_addr_reg < ADDR_W'(FRAME_WORDS));

`ifdef FB_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] wait_cnt_reg;

  assign starve = (wait_cnt_reg == SW'(STARVE_MAX)) && (fifo_count != '0);

  // Count cycles the host has been refused; saturates at the limit
  always_ff @(posedge OSC_50 or negedge RST_N) begin
    if (!RST_N)
      wait_cnt_reg <= '0;
    else if (!WR_VALID || WR_READY)
      wait_cnt_reg <= '0;
    else if (wait_cnt_reg != SW'(STARVE_MAX))
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
  end
`else
  assign starve = 1'b0;
`endif

  // Grant priority: urgent refill, then host write, then opportunistic refill
  always_comb begin
    grant_next = IDLE;
    if (FRAME_START)
      grant_next = IDLE;
    else if (fetch_ok && (fill < FILL_W'(LOW_WATER)) && !starve)
      grant_next = FETCH;
    else if (WR_VALID)
      grant_next = WRITE;
    else if (fetch_ok)
      grant_next = FETCH;
  end

  assign WR_READY = (grant_next == WRITE);

  // Grant FSM with registered memory-port outputs
  always_ff @(posedge OSC_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_reg     <= IDLE;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      state_reg  <= grant_next;
      mem_en_reg <= (grant_next != IDLE);
      mem_we_reg <= (grant_next == WRITE);
      case (grant_next)
        FETCH: mem_addr_reg <= fetch_addr_reg;
        WRITE: begin
          mem_addr_reg  <= WR_ADDR;
          mem_wdata_reg <= WR_DATA;
        end
        default: mem_addr_reg <= mem_addr_reg;
      endcase
    end
  end

  // Scan-out address; stops at the frame end until the next frame start
  always_ff @(posedge OSC_50 or negedge RST_N) begin
    if (!RST_N)
      fetch_addr_reg <= '0;
    else if (FRAME_START)
      fetch_addr_reg <= '0;
    else if (grant_next == FETCH)
      fetch_addr_reg <= fetch_addr_reg + 1'b1;
  end

  // Track read data arrival; a read on the bus at frame start turns stale
  always_ff @(posedge OSC_50 or negedge RST_N) begin
    if (!RST_N) begin
      rd_data_reg       <= 1'b0;
      rd_data_stale_reg <= 1'b0;
    end else begin
      rd_data_reg       <= rd_bus;
      rd_data_stale_reg <= FRAME_START;
    end
  end

  // Sticky underrun flag, cleared only at frame start
  always_ff @(posedge OSC_50 or negedge RST_N) begin
    if (!RST_N)
      underrun_reg <= 1'b0;
    else if (FRAME_START)
      underrun_reg <= 1'b0;
    else if (POP && fifo_empty)
      underrun_reg <= 1'b1;
  end

  assign fifo_push = rd_data_reg & ~rd_data_stale_reg;

  vga_fb_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (OSC_50),
    .rst_n     (RST_N),
    .push      (fifo_push),
    .push_data (MEM_RDATA),
    .pop       (POP),
    .flush     (FRAME_START),
    .head_data (POP_DATA),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign FIFO_EMPTY = fifo_empty;
  assign UNDERRUN   = underrun_reg;
  assign MEM_EN     = mem_en_reg;
  assign MEM_WE     = mem_we_reg;
  assign MEM_ADDR   = mem_addr_reg;
  assign MEM_WDATA  = mem_wdata_reg;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: random and directed stimulus
// checked every cycle against a transaction-level model (FIFO as a queue,
// outstanding reads as a queue of due-cycle tagged words, RAM image array).
module tb_vga_fb_arbiter;

  localparam int AW    = 15;
  localparam int DW    = 16;
  localparam int FW    = 19200;
  localparam int DEPTH = 4;
  localparam int LOWW  = 2;
  localparam int SMAX  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fs = 1'b0;
  logic          pop = 1'b0;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] pop_data;
  logic          fifo_empty, underrun, wr_ready, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .OSC_50      (clk),
    .RST_N       (rst_n),
    .FRAME_START (fs),
    .POP         (pop),
    .POP_DATA    (pop_data),
    .FIFO_EMPTY  (fifo_empty),
    .UNDERRUN    (underrun),
    .WR_VALID    (wr_valid),
    .WR_READY    (wr_ready),
    .WR_ADDR     (wr_addr),
    .WR_DATA     (wr_data),
    .MEM_EN      (mem_en),
    .MEM_WE      (mem_we),
    .MEM_ADDR    (mem_addr),
    .MEM_WDATA   (mem_wdata),
    .MEM_RDATA   (mem_rdata)
  );

  // Single-port RAM with one-cycle read latency
  logic [DW-1:0] ram [FW];
  bit            ram_init = 1'b1;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < FW; i++) ram[i] <= DW'(i);
    end else if (mem_en) begin
      if (mem_we) begin
        if (int'(mem_addr) < FW) ram[mem_addr] <= mem_wdata;
      end else begin
        mem_rdata <= (int'(mem_addr) < FW) ? ram[mem_addr] : 16'hDEAD;
      end
    end
  end

  // Reference model state
  typedef struct {
    logic [DW-1:0] data;
    bit            stale;
    int            due;
  } rd_t;

  logic [DW-1:0] img [FW];
  logic [DW-1:0] q [$];
  rd_t           inf_q [$];
  int            fa, cyc, wait_cnt;
  bit            m_underrun;
  bit            e_en, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  bit            wr_accepted;

  int n_vec = 0;
  int n_miss = 0;
  int rd_count = 0;
  int last_rd_addr = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    inf_q.delete();
    fa = 0;
    m_underrun = 1'b0;
    e_en = 1'b0;
    e_we = 1'b0;
    e_addr = '0;
    e_wdata = '0;
    wait_cnt = 0;
    wr_accepted = 1'b0;
  endtask

  task automatic reset_checks();
    check("rst_pop_data", 32'(pop_data), 32'd0);
    check("rst_fifo_empty", 32'(fifo_empty), 32'd1);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
  endtask

  // One clock cycle: compare outputs with the model, then advance the model
  task automatic step();
    int  fill;
    bit  fok, starve, do_fetch, do_write;
    rd_t r;
    logic [DW-1:0] head;
    #2;
    head = (q.size() != 0) ? q[0] : '0;
    check("pop_data", 32'(pop_data), 32'(head));
    check("fifo_empty", 32'(fifo_empty), 32'(q.size() == 0));
    check("underrun", 32'(underrun), 32'(m_underrun));

    fill = q.size() + inf_q.size();
    fok  = (fill < DEPTH) && (fa < FW);
    starve = 1'b0;
`ifdef FB_ARB_STARVE_EN
    starve = (wait_cnt == SMAX) && (q.size() >= 1);
`endif
    do_fetch = 1'b0;
    do_write = 1'b0;
    if (!fs) begin
      if (fok && fill < LOWW && !starve) do_fetch = 1'b1;
      else if (wr_valid)                 do_write = 1'b1;
      else if (fok)                      do_fetch = 1'b1;
    end
    check("wr_ready", 32'(wr_ready), 32'(do_write));
    check("mem_en", 32'(mem_en), 32'(e_en));
    if (e_en) begin
      check("mem_we", 32'(mem_we), 32'(e_we));
      check("mem_addr", 32'(mem_addr), 32'(e_addr));
      if (e_we) check("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    end
    if (mem_en && !mem_we) begin
      rd_count++;
      last_rd_addr = int'(mem_addr);
    end

    if (fs) begin
      q.delete();
      fa = 0;
      m_underrun = 1'b0;
      foreach (inf_q[i]) inf_q[i].stale = 1'b1;
    end else if (pop) begin
      if (q.size() != 0) void'(q.pop_front());
      else m_underrun = 1'b1;
    end
    while (inf_q.size() != 0 && inf_q[0].due == cyc) begin
      r = inf_q.pop_front();
      if (!r.stale && !fs) q.push_back(r.data);
    end

    if (do_fetch) begin
      inf_q.push_back('{img[fa], 1'b0, cyc + 2});
      e_en = 1'b1; e_we = 1'b0; e_addr = AW'(fa);
      fa++;
    end else if (do_write) begin
      img[wr_addr] = wr_data;
      e_en = 1'b1; e_we = 1'b1; e_addr = wr_addr; e_wdata = wr_data;
    end else begin
      e_en = 1'b0;
    end
    if (!wr_valid || do_write) wait_cnt = 0;
    else if (wait_cnt < SMAX) wait_cnt++;
    wr_accepted = do_write;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Random inputs; a refused write keeps its address and data
  task automatic drive(input int pop_pct, input int wr_pct, input int fs_pm);
    pop = ($urandom_range(0, 99) < pop_pct);
    fs  = ($urandom_range(0, 999) < fs_pm);
    if (!wr_valid || wr_accepted) begin
      wr_valid = ($urandom_range(0, 99) < wr_pct);
      wr_addr  = AW'($urandom_range(0, FW - 1));
      wr_data  = DW'($urandom);
    end
  endtask

  task automatic mid_reset();
    wr_valid = 1'b0; fs = 1'b0; pop = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #2;
    reset_checks();
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int guard;
    for (int i = 0; i < FW; i++) img[i] = DW'(i);
    model_reset();
    cyc = 0;
    @(posedge clk); #1;
    ram_init = 1'b0;
    #2;
    reset_checks();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Frame start with no consumer: exactly four reads fill the FIFO
    fs = 1'b1; step(); fs = 1'b0;
    rd_count = 0;
    for (int i = 0; i < 12; i++) step();
    check("t1_reads", 32'(rd_count), 32'd4);
    check("t1_pop_data", 32'(pop_data), 32'(img[0]));
    check("t1_not_empty", 32'(fifo_empty), 32'd0);

    // Host write while the FIFO is full
    wr_valid = 1'b1; wr_addr = 15'h1234; wr_data = 16'hBEEF;
    #2;
    check("t5_wr_ready", 32'(wr_ready), 32'd1);
    step();
    wr_valid = 1'b0;
    check("t5_mem_en", 32'(mem_en), 32'd1);
    check("t5_mem_we", 32'(mem_we), 32'd1);
    check("t5_mem_addr", 32'(mem_addr), 32'h1234);
    check("t5_mem_wdata", 32'(mem_wdata), 32'hBEEF);
    step();

    // Underrun from an empty FIFO after reset, cleared by frame start
    mid_reset();
    pop = 1'b1;
    step();
    check("t3_underrun", 32'(underrun), 32'd1);
    check("t3_pop_data", 32'(pop_data), 32'd0);
    step(); step(); step();
    pop = 1'b0; fs = 1'b1; step(); fs = 1'b0;
    check("t3_cleared", 32'(underrun), 32'd0);

    // Frame start with two reads outstanding: first word after is img[0]
    for (int i = 0; i < 3; i++) step();
    fs = 1'b1; step(); fs = 1'b0;
    step(); step();
    fs = 1'b1; step(); fs = 1'b0;
    guard = 0;
    while (fifo_empty && guard < 10) begin step(); guard++; end
    check("t4_timeout", 32'(guard < 10), 32'd1);
    check("t4_first_word", 32'(pop_data), 32'(img[0]));

    // Steady scan-out every 16 cycles with the host always requesting
    fs = 1'b1; step(); fs = 1'b0;
    rd_count = 0;
    for (int i = 0; i < 1600; i++) begin
      pop = (i % 16 == 15);
      if (!wr_valid || wr_accepted) begin
        wr_valid = 1'b1;
        wr_addr  = AW'($urandom_range(0, FW - 1));
        wr_data  = DW'($urandom);
      end
      step();
    end
    check("t2_no_underrun", 32'(underrun), 32'd0);

    // Finish the frame with a fast consumer; fetch stops at the last word
    guard = 0;
    while ((fa < FW || inf_q.size() != 0) && guard < 60000) begin
      drive(85, 50, 0);
      step();
      guard++;
    end
    check("t2_timeout", 32'(guard < 60000), 32'd1);
    for (int i = 0; i < 8; i++) begin drive(85, 50, 0); step(); end
    check("t2_read_count", 32'(rd_count), 32'(FW));
    check("t2_last_addr", 32'(last_rd_addr), 32'(FW - 1));

    // Mixed random traffic with sporadic frame starts and one reset
    for (int i = 0; i < 1500; i++) begin drive(50, 60, 5); step(); end
    mid_reset();
    for (int i = 0; i < 1500; i++) begin drive(60, 50, 5); step(); end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
